// File: rtl/ps2_flap_decoder.sv
// rtl/ps2_flap_decoder.sv - Set-2 scan-code parser producing rate-limited flap events.
// Optional FLAP_QUEUE_EN: flap_req backed by a saturating 2-bit pending count.
module ps2_flap_decoder #(
    parameter logic [7:0] FLAP_CODE       = 8'h29,
    parameter int         COOLDOWN_CYCLES = 1250000,
    parameter int         PREFIX_TIMEOUT  = 500000,
    parameter int         CNT_W           = 21
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  key_data,
    input  logic        key_valid,
    input  logic        flap_ack,
    output logic        flap_pulse,
    output logic        flap_req,
    output logic        key_held,
    output logic [7:0]  last_code,
    output logic [15:0] flap_count
);
    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(PREFIX_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cool_q, cool_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic             held_q, held_d;
    logic [7:0]       last_q, last_d;
    logic [15:0]      count_q, count_d;
    logic             pulse_q, pulse_d;
    logic             accept;
`ifdef FLAP_QUEUE_EN
    logic [1:0]       pend_q, pend_d;
`else
    logic             req_q, req_d;
`endif

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        held_d  = held_q;
        last_d  = last_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    if (key_data == 8'hE0) begin
                        state_d = EXT;
                    end else if (key_data == 8'hF0) begin
                        state_d = BRK;
                    end else begin
                        last_d = key_data;
                        if (key_data == FLAP_CODE) begin
                            held_d = 1'b1;
                            // Held key means typematic repeat; cooldown rate-limits fresh presses.
                            accept = !held_q && (cool_q == '0);
                        end
                    end
                end
            end
            BRK: begin
                if (key_valid) begin
                    last_d  = key_data;
                    state_d = IDLE;
                    if (key_data == FLAP_CODE) held_d = 1'b0;
                end
            end
            EXT: begin
                if (key_valid) begin
                    if (key_data == 8'hF0) begin
                        state_d = EXT_BRK;
                    end else begin
                        last_d  = key_data;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                if (key_valid) begin
                    last_d  = key_data;
                    state_d = IDLE;
                end
            end
        endcase

        // A byte arriving on the last timeout cycle is handled above and takes precedence.
        if (state_q != IDLE && !key_valid) begin
            if (tmo_q == TMO_LAST) state_d = IDLE;
            else                   tmo_d   = tmo_q + CNT_ONE;
        end
        if (state_d == IDLE || state_d != state_q) tmo_d = '0;

        if (accept)             cool_d = COOL_LOAD;
        else if (cool_q != '0)  cool_d = cool_q - CNT_ONE;
        else                    cool_d = cool_q;

        pulse_d = accept;
        count_d = count_q + 16'(accept);

`ifdef FLAP_QUEUE_EN
        pend_d = pend_q;
        if (accept && !flap_ack && pend_q != 2'd3) pend_d = pend_q + 2'd1;
        else if (!accept && flap_ack && pend_q != 2'd0) pend_d = pend_q - 2'd1;
`else
        req_d = accept || (req_q && !flap_ack);
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cool_q  <= '0;
            tmo_q   <= '0;
            held_q  <= 1'b0;
            last_q  <= 8'h00;
            count_q <= 16'h0000;
            pulse_q <= 1'b0;
`ifdef FLAP_QUEUE_EN
            pend_q  <= 2'd0;
`else
            req_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cool_q  <= cool_d;
            tmo_q   <= tmo_d;
            held_q  <= held_d;
            last_q  <= last_d;
            count_q <= count_d;
            pulse_q <= pulse_d;
`ifdef FLAP_QUEUE_EN
            pend_q  <= pend_d;
`else
            req_q   <= req_d;
`endif
        end
    end

    assign flap_pulse = pulse_q;
    assign key_held   = held_q;
    assign last_code  = last_q;
    assign flap_count = count_q;
`ifdef FLAP_QUEUE_EN
    assign flap_req   = (pend_q != 2'd0);
`else
    assign flap_req   = req_q;
`endif
endmodule
